// File: rtl/aabb_closest_hit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : aabb_closest_hit_pipe
// Brief    : Pipelined ray/AABB slab test with per-ray closest-hit reduction.
// Revision : 1.0 - initial release
// ============================================================================
module aabb_closest_hit_pipe #(
  parameter int WIDTH  = 20,
  parameter int Q_BITS = 12,
  parameter int TAG_W  = 4,
  parameter int IDX_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [3*WIDTH-1:0]   in_origin,
  input  logic [3*WIDTH-1:0]   in_inv_dir,
  input  logic [2:0]           in_dir_zero,
  input  logic [3*WIDTH-1:0]   in_box_min,
  input  logic [3*WIDTH-1:0]   in_box_max,
  input  logic [IDX_W-1:0]     in_box_idx,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_hit,
  output logic [WIDTH-1:0]     out_tmin,
  output logic [IDX_W-1:0]     out_box_idx,
  output logic [1:0]           out_axis,
  output logic                 out_normal_neg
);

  localparam logic signed [WIDTH-1:0]   c_max  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   c_min  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] c_pmax = {{WIDTH{1'b0}}, c_max};
  localparam logic signed [2*WIDTH-1:0] c_pmin = {{WIDTH{1'b1}}, c_min};
  localparam logic [1:0]                c_axis_none = 2'd3;

  function automatic logic signed [WIDTH-1:0] sat_d(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? c_min : c_max;
    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_p(input logic signed [2*WIDTH-1:0] v);
    if (v > c_pmax) return c_max;
    if (v < c_pmin) return c_min;
    return v[WIDTH-1:0];
  endfunction

  // A held, unconsumed result freezes the whole pipe.
  logic w_en;
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  // ---------------- S1: offsets and zero-direction slab test ----------------
  logic signed [WIDTH-1:0] w_d1 [3];
  logic signed [WIDTH-1:0] w_d2 [3];
  logic [2:0]              w_zmiss;

  for (genvar a = 0; a < 3; a++) begin : g_s1
    logic signed [WIDTH-1:0] w_org, w_min, w_max;
    logic signed [WIDTH:0]   w_d1_full, w_d2_full;
    assign w_org      = in_origin[a*WIDTH +: WIDTH];
    assign w_min      = in_box_min[a*WIDTH +: WIDTH];
    assign w_max      = in_box_max[a*WIDTH +: WIDTH];
    assign w_d1_full  = {w_min[WIDTH-1], w_min} - {w_org[WIDTH-1], w_org};
    assign w_d2_full  = {w_max[WIDTH-1], w_max} - {w_org[WIDTH-1], w_org};
    assign w_d1[a]    = sat_d(w_d1_full);
    assign w_d2[a]    = sat_d(w_d2_full);
    assign w_zmiss[a] = in_dir_zero[a] && !((w_min <= w_org) && (w_org <= w_max));
  end

  logic                    r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [WIDTH-1:0] r_s1_d1 [3];
  logic signed [WIDTH-1:0] r_s1_d2 [3];
  logic signed [WIDTH-1:0] r_s1_inv [3];
  logic [2:0]              r_s1_dz, r_s1_zmiss;
  logic [TAG_W-1:0]        r_s1_tag;
  logic [IDX_W-1:0]        r_s1_idx;
  logic                    r_s1_last;

  // ---------------- S2: slab distances ----------------
  logic signed [WIDTH-1:0] w_t1 [3];
  logic signed [WIDTH-1:0] w_t2 [3];

  for (genvar a = 0; a < 3; a++) begin : g_s2
    logic signed [2*WIDTH-1:0] w_p1, w_p2;
    assign w_p1    = r_s1_d1[a] * r_s1_inv[a];
    assign w_p2    = r_s1_d2[a] * r_s1_inv[a];
    assign w_t1[a] = r_s1_dz[a] ? c_min : sat_p(w_p1 >>> Q_BITS);
    assign w_t2[a] = r_s1_dz[a] ? c_max : sat_p(w_p2 >>> Q_BITS);
  end

  logic signed [WIDTH-1:0] r_s2_t1 [3];
  logic signed [WIDTH-1:0] r_s2_t2 [3];
  logic [2:0]              r_s2_zmiss, r_s2_invneg;
  logic [TAG_W-1:0]        r_s2_tag;
  logic [IDX_W-1:0]        r_s2_idx;
  logic                    r_s2_last;

  // ---------------- S3: interval reduction ----------------
  logic signed [WIDTH-1:0] w_lo [3];
  logic signed [WIDTH-1:0] w_hi [3];

  for (genvar a = 0; a < 3; a++) begin : g_s3
    assign w_lo[a] = (r_s2_t1[a] < r_s2_t2[a]) ? r_s2_t1[a] : r_s2_t2[a];
    assign w_hi[a] = (r_s2_t1[a] < r_s2_t2[a]) ? r_s2_t2[a] : r_s2_t1[a];
  end

  logic signed [WIDTH-1:0] w_tnear, w_tfar, w_tc;
  logic [1:0]              w_tnear_axis, w_axis;
  logic                    w_hit, w_nneg, w_sel_neg;

  always_comb begin
    // Strict compares keep the lower axis on ties.
    w_tnear      = w_lo[0];
    w_tnear_axis = 2'd0;
    if (w_lo[1] > w_tnear) begin w_tnear = w_lo[1]; w_tnear_axis = 2'd1; end
    if (w_lo[2] > w_tnear) begin w_tnear = w_lo[2]; w_tnear_axis = 2'd2; end
    w_tfar = w_hi[0];
    if (w_hi[1] < w_tfar) w_tfar = w_hi[1];
    if (w_hi[2] < w_tfar) w_tfar = w_hi[2];
    w_tc   = w_tnear[WIDTH-1] ? '0 : w_tnear;
    w_hit  = !(|r_s2_zmiss) && (w_tfar >= w_tc);
    w_axis = w_tnear[WIDTH-1] ? c_axis_none : w_tnear_axis;
    case (w_tnear_axis)
      2'd0:    w_sel_neg = r_s2_invneg[0];
      2'd1:    w_sel_neg = r_s2_invneg[1];
      default: w_sel_neg = r_s2_invneg[2];
    endcase
    w_nneg = (w_axis != c_axis_none) && !w_sel_neg;
  end

  logic                    r_s3_hit, r_s3_nneg, r_s3_last;
  logic signed [WIDTH-1:0] r_s3_tc;
  logic [1:0]              r_s3_axis;
  logic [TAG_W-1:0]        r_s3_tag;
  logic [IDX_W-1:0]        r_s3_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int a = 0; a < 3; a++) begin
        r_s1_d1[a]     <= w_d1[a];
        r_s1_d2[a]     <= w_d2[a];
        r_s1_inv[a]    <= in_inv_dir[a*WIDTH +: WIDTH];
        r_s2_t1[a]     <= w_t1[a];
        r_s2_t2[a]     <= w_t2[a];
        r_s2_invneg[a] <= r_s1_inv[a][WIDTH-1];
      end
      r_s1_dz    <= in_dir_zero;
      r_s1_zmiss <= w_zmiss;
      r_s1_tag   <= in_tag;
      r_s1_idx   <= in_box_idx;
      r_s1_last  <= in_last;
      r_s2_zmiss <= r_s1_zmiss;
      r_s2_tag   <= r_s1_tag;
      r_s2_idx   <= r_s1_idx;
      r_s2_last  <= r_s1_last;
      r_s3_hit   <= w_hit;
      r_s3_tc    <= w_tc;
      r_s3_axis  <= w_axis;
      r_s3_nneg  <= w_nneg;
      r_s3_tag   <= r_s2_tag;
      r_s3_idx   <= r_s2_idx;
      r_s3_last  <= r_s2_last;
    end
  end

  // ---------------- S4: closest-hit accumulator ----------------
  logic                    r_open, r_best_hit, r_best_nneg;
  logic signed [WIDTH-1:0] r_best_tmin;
  logic [IDX_W-1:0]        r_best_idx;
  logic [1:0]              r_best_axis;
  logic [TAG_W-1:0]        r_tag;

  logic                    w_upd, w_new_hit, w_new_nneg;
  logic signed [WIDTH-1:0] w_new_tmin;
  logic [IDX_W-1:0]        w_new_idx;
  logic [1:0]              w_new_axis;
  logic [TAG_W-1:0]        w_new_tag;

  always_comb begin
    // A closed accumulator behaves as if freshly loaded with the miss result.
    w_new_hit  = r_open ? r_best_hit  : 1'b0;
    w_new_tmin = r_open ? r_best_tmin : c_max;
    w_new_idx  = r_open ? r_best_idx  : '0;
    w_new_axis = r_open ? r_best_axis : c_axis_none;
    w_new_nneg = r_open ? r_best_nneg : 1'b0;
    w_new_tag  = r_open ? r_tag       : r_s3_tag;
    w_upd      = r_s3_hit && (!r_open || (r_s3_tc < r_best_tmin));
    if (w_upd) begin
      w_new_hit  = 1'b1;
      w_new_tmin = r_s3_tc;
      w_new_idx  = r_s3_idx;
      w_new_axis = r_s3_axis;
      w_new_nneg = r_s3_nneg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_open         <= 1'b0;
      r_best_hit     <= 1'b0;
      r_best_tmin    <= c_max;
      r_best_idx     <= '0;
      r_best_axis    <= c_axis_none;
      r_best_nneg    <= 1'b0;
      r_tag          <= '0;
      out_valid      <= 1'b0;
      out_tag        <= '0;
      out_hit        <= 1'b0;
      out_tmin       <= c_max;
      out_box_idx    <= '0;
      out_axis       <= c_axis_none;
      out_normal_neg <= 1'b0;
    end else if (w_en) begin
      if (r_s3_valid) begin
        r_open      <= !r_s3_last;
        r_best_hit  <= w_new_hit;
        r_best_tmin <= w_new_tmin;
        r_best_idx  <= w_new_idx;
        r_best_axis <= w_new_axis;
        r_best_nneg <= w_new_nneg;
        r_tag       <= w_new_tag;
      end
      out_valid <= r_s3_valid && r_s3_last;
      if (r_s3_valid && r_s3_last) begin
        out_tag        <= w_new_tag;
        out_hit        <= w_new_hit;
        out_tmin       <= w_new_tmin;
        out_box_idx    <= w_new_idx;
        out_axis       <= w_new_axis;
        out_normal_neg <= w_new_nneg;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aabb_closest_hit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_aabb_closest_hit_pipe
// Brief    : Directed self-checking bench for aabb_closest_hit_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aabb_closest_hit_pipe;

  localparam logic [19:0] c_max = 20'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_tag = '0;
  logic [59:0] in_origin = '0, in_inv_dir = '0, in_box_min = '0, in_box_max = '0;
  logic [2:0]  in_dir_zero = '0;
  logic [7:0]  in_box_idx = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_tag;
  logic        out_hit;
  logic [19:0] out_tmin;
  logic [7:0]  out_box_idx;
  logic [1:0]  out_axis;
  logic        out_normal_neg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  typedef struct {
    logic [3:0]  tag;
    logic        hit;
    logic [19:0] tmin;
    logic [7:0]  idx;
    logic [1:0]  axis;
    logic        nneg;
    int          cyc;
  } res_t;
  res_t q[$];

  aabb_closest_hit_pipe #(.WIDTH(20), .Q_BITS(12), .TAG_W(4), .IDX_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_origin(in_origin), .in_inv_dir(in_inv_dir), .in_dir_zero(in_dir_zero),
    .in_box_min(in_box_min), .in_box_max(in_box_max), .in_box_idx(in_box_idx),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_hit(out_hit), .out_tmin(out_tmin), .out_box_idx(out_box_idx),
    .out_axis(out_axis), .out_normal_neg(out_normal_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A result seen at the falling edge with out_ready high is consumed next edge.
  always @(negedge clk) begin
    res_t r;
    if (!reset && out_valid && out_ready) begin
      r.tag = out_tag; r.hit = out_hit; r.tmin = out_tmin; r.idx = out_box_idx;
      r.axis = out_axis; r.nneg = out_normal_neg; r.cyc = cyc;
      q.push_back(r);
    end
  end

  function automatic logic [59:0] v3(input int z, input int y, input int x);
    logic [19:0] a, b, c;
    a = 20'(z * 4096); b = 20'(y * 4096); c = 20'(x * 4096);
    return {a, b, c};
  endfunction

  task automatic send(input logic [3:0] tag, input logic [59:0] org, input logic [59:0] inv,
                      input logic [2:0] dz, input logic [59:0] bmin, input logic [59:0] bmax,
                      input logic [7:0] idx, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_tag = tag; in_origin = org; in_inv_dir = inv; in_dir_zero = dz;
    in_box_min = bmin; in_box_max = bmax; in_box_idx = idx; in_last = last;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready got %b required 1", in_ready);
    end
    last_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    for (int k = 0; k < 100 && q.size() < n; k++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    ok = (q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({out_valid, out_hit, out_tmin, out_tag, out_box_idx, out_axis, out_normal_neg} !==
        {1'b0, 1'b0, c_max, 4'd0, 8'd0, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got v=%b h=%b t=%h tag=%h i=%h a=%0d n=%b",
               out_valid, out_hit, out_tmin, out_tag, out_box_idx, out_axis, out_normal_neg);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_zero_axis_hit();
    res_t r; bit ok;
    q.delete();
    send(4'd3, v3(-5, 0, 0), v3(1, 0, 0), 3'b011, v3(-1, -1, -1), v3(1, 1, 1), 8'd9, 1'b1);
    wait_results(1, ok);
    checks++;
    if (q.size() !== 1) begin errors++; $display("FAIL hit1_count got %0d required 1", q.size()); end
    if (ok) begin
      r = q[0];
      checks++;
      if (r.tmin !== 20'h04000) begin errors++; $display("FAIL hit1_tmin got %h required 04000", r.tmin); end
      checks++;
      if ({r.tag, r.hit, r.idx, r.axis, r.nneg} !== {4'd3, 1'b1, 8'd9, 2'd2, 1'b1}) begin
        errors++;
        $display("FAIL hit1_fields got tag=%0d h=%b i=%0d a=%0d n=%b required 3 1 9 2 1",
                 r.tag, r.hit, r.idx, r.axis, r.nneg);
      end
      checks++;
      if (r.cyc - last_cyc !== 4) begin errors++; $display("FAIL hit1_latency got %0d required 4", r.cyc - last_cyc); end
    end
  endtask

  task automatic test_zero_axis_miss();
    res_t r; bit ok;
    q.delete();
    send(4'd4, v3(-5, 0, 0), v3(1, 0, 0), 3'b011, v3(-1, -1, 2), v3(1, 1, 3), 8'd9, 1'b1);
    wait_results(1, ok);
    if (ok) r = q[0];
    checks++;
    if ({r.tag, r.hit, r.tmin, r.idx, r.axis, r.nneg} !== {4'd4, 1'b0, c_max, 8'd0, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL zmiss got tag=%0d h=%b t=%h i=%0d a=%0d n=%b required 4 0 7ffff 0 3 0",
               r.tag, r.hit, r.tmin, r.idx, r.axis, r.nneg);
    end
  endtask

  task automatic test_inside();
    res_t r; bit ok;
    q.delete();
    send(4'd2, v3(0, 0, 0), v3(1, 1, 1), 3'b000, v3(-1, -1, -1), v3(1, 1, 1), 8'd1, 1'b1);
    wait_results(1, ok);
    if (ok) r = q[0];
    checks++;
    if ({r.tag, r.hit, r.tmin, r.idx, r.axis} !== {4'd2, 1'b1, 20'h00000, 8'd1, 2'd3}) begin
      errors++;
      $display("FAIL inside got tag=%0d h=%b t=%h i=%0d a=%0d required 2 1 00000 1 3",
               r.tag, r.hit, r.tmin, r.idx, r.axis);
    end
  endtask

  task automatic test_negative_dir();
    res_t r; bit ok;
    q.delete();
    send(4'd8, v3(0, 0, 10), v3(0, 0, -1), 3'b110, v3(-1, -1, 2), v3(1, 1, 4), 8'd12, 1'b1);
    wait_results(1, ok);
    if (ok) r = q[0];
    checks++;
    if ({r.tag, r.hit, r.tmin, r.idx, r.axis, r.nneg} !== {4'd8, 1'b1, 20'h06000, 8'd12, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL negdir got tag=%0d h=%b t=%h i=%0d a=%0d n=%b required 8 1 06000 12 0 0",
               r.tag, r.hit, r.tmin, r.idx, r.axis, r.nneg);
    end
  endtask

  task automatic test_closest();
    res_t r; bit ok;
    q.delete();
    send(4'd6, v3(0, 0, 0), v3(0, 0, 1), 3'b110, v3(-1, -1, 8), v3(1, 1, 9), 8'd5, 1'b0);
    send(4'd6, v3(0, 0, 0), v3(0, 0, 1), 3'b110, v3(-1, -1, 3), v3(1, 1, 4), 8'd6, 1'b0);
    send(4'd6, v3(0, 0, 0), v3(0, 0, 1), 3'b110, v3(-1, -1, 3), v3(1, 1, 5), 8'd7, 1'b1);
    wait_results(1, ok);
    checks++;
    if (q.size() !== 1) begin errors++; $display("FAIL closest_count got %0d required 1", q.size()); end
    if (ok) r = q[0];
    checks++;
    if ({r.tag, r.hit, r.tmin, r.idx, r.axis, r.nneg} !== {4'd6, 1'b1, 20'h03000, 8'd6, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL closest got tag=%0d h=%b t=%h i=%0d a=%0d n=%b required 6 1 03000 6 0 1",
               r.tag, r.hit, r.tmin, r.idx, r.axis, r.nneg);
    end
  endtask

  task automatic test_saturate();
    res_t r; bit ok;
    q.delete();
    send(4'd9, v3(0, 0, 0), v3(0, 1, 100), 3'b100, v3(-1, -1, 100), v3(1, 1, 120), 8'd3, 1'b1);
    wait_results(1, ok);
    if (ok) r = q[0];
    checks++;
    if ({r.tag, r.hit, r.tmin, r.axis} !== {4'd9, 1'b0, c_max, 2'd3}) begin
      errors++;
      $display("FAIL saturate got tag=%0d h=%b t=%h a=%0d required 9 0 7ffff 3",
               r.tag, r.hit, r.tmin, r.axis);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, saw_low;
    logic [3:0] held_tag;
    logic       held_valid;
    q.delete();
    saw_low = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 3; t++)
          send(4'(t), v3(-5, 0, 0), v3(1, 0, 0), 3'b011, v3(-1, -1, -1), v3(1, 1, 1), 8'(t), 1'b1);
      end
      begin
        repeat (10) begin @(negedge clk); if (!in_ready) saw_low = 1'b1; end
        held_valid = out_valid; held_tag = out_tag;
        @(posedge clk); #2 out_ready = 1'b1;
      end
    join
    checks++;
    if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_in_ready_drop got %b required 1", saw_low); end
    checks++;
    if ({held_valid, held_tag} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL bp_held got v=%b tag=%0d required 1 1", held_valid, held_tag);
    end
    wait_results(3, ok);
    checks++;
    if (q.size() !== 3) begin errors++; $display("FAIL bp_count got %0d required 3", q.size()); end
    if (ok) begin
      checks++;
      if ({q[0].tag, q[1].tag, q[2].tag} !== {4'd1, 4'd2, 4'd3}) begin
        errors++; $display("FAIL bp_order got %0d %0d %0d required 1 2 3", q[0].tag, q[1].tag, q[2].tag);
      end
    end
  endtask

  task automatic test_reset_midray();
    res_t r; bit ok;
    q.delete();
    send(4'd7, v3(-5, 0, 0), v3(1, 0, 0), 3'b011, v3(-1, -1, -1), v3(1, 1, 1), 8'd1, 1'b0);
    send(4'd7, v3(-5, 0, 0), v3(1, 0, 0), 3'b011, v3(-1, -1, -1), v3(1, 1, 1), 8'd2, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send(4'd5, v3(-10, 0, 0), v3(1, 0, 0), 3'b011, v3(-1, -1, -1), v3(1, 1, 1), 8'd11, 1'b1);
    wait_results(1, ok);
    checks++;
    if (q.size() !== 1) begin errors++; $display("FAIL rst_count got %0d required 1", q.size()); end
    if (ok) r = q[0];
    checks++;
    if ({r.tag, r.hit, r.tmin, r.idx} !== {4'd5, 1'b1, 20'h09000, 8'd11}) begin
      errors++;
      $display("FAIL rst_result got tag=%0d h=%b t=%h i=%0d required 5 1 09000 11",
               r.tag, r.hit, r.tmin, r.idx);
    end
  endtask

  initial begin
    test_reset();
    test_zero_axis_hit();
    test_zero_axis_miss();
    test_inside();
    test_negative_dir();
    test_closest();
    test_saturate();
    test_back_to_back();
    test_reset_midray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
